divider_config_sequencer: RTL and testbench

//  Controller for the pulse divider. Serially loads 32b divider-target and row-points values into the

---
 rtl/divider_config_sequencer_if.sv | 30 +++
 rtl/divider_config_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_divider_config_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_config_sequencer_if.sv
// Software-side bundle for the pulse divider controller: configuration load
// handshake, run control and run status.
// master = control-software side, slave = divider_config_sequencer.
interface divider_config_sequencer_if #(
  parameter int unsigned ROW_W = 16
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_select;
  logic [31:0]      cfg_value;
  logic             run_start;
  logic [ROW_W-1:0] run_rows;
  logic             run_abort;
  logic             busy;
  logic [ROW_W-1:0] row_index;
  logic             row_done_pulse;
  logic             run_done_pulse;

  modport master (
    output cfg_valid, cfg_select, cfg_value, run_start, run_rows, run_abort,
    input  cfg_ready, busy, row_index, row_done_pulse, run_done_pulse
  );

  modport slave (
    input  cfg_valid, cfg_select, cfg_value, run_start, run_rows, run_abort,
    output cfg_ready, busy, row_index, row_done_pulse, run_done_pulse
  );

endinterface

// File: rtl/divider_config_sequencer.sv
// Pulse divider controller.
// Serially loads a 32-bit word (MSB first) into either the divider-target or
// the row-points shift register, then sequences row acquisition
// (arm, wait for row_complete, re-arm) and counts completed rows.
// Optional build macro CFG_CLEAR_BEFORE_LOAD_EN: a one-cycle CLEAR state
// pulses the selected shift register's clear line before every load.
module divider_config_sequencer #(
  parameter int unsigned SCLK_HALF = 4,
  parameter int unsigned ROW_W     = 16
) (
  input  logic                      control_clock,
  input  logic                      external_reset,
  divider_config_sequencer_if.slave sw,
  input  logic                      row_complete,
  output logic                      sr_data,
  output logic                      sr_data_clock,
  output logic                      sr_div_data_enable,
  output logic                      sr_div_data_reset,
  output logic                      sr_row_data_enable,
  output logic                      sr_row_data_reset,
  output logic                      div_enable,
  output logic                      rowpack_enable,
  output logic                      row_starting,
  output logic                      reset_row
);

  localparam int unsigned CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  typedef enum logic [3:0] {
    IDLE,
`ifdef CFG_CLEAR_BEFORE_LOAD_EN
    CLEAR,
`endif
    SHIFT_LO,
    SHIFT_HI,
    GUARD,
    ARM,
    WAIT_ROW,
    ROW_GAP,
    FINISH
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] half_cnt;
  logic [4:0]       bit_idx;
  logic [31:0]      load_value;
  logic             load_select;
  logic [ROW_W-1:0] rows_target;
  logic [ROW_W-1:0] row_index_q;
  logic [ROW_W-1:0] row_index_inc;
  logic             row_done_q;

  logic             rc_sync1;
  logic             rc_sync2;
  logic             rc_prev;

  logic             half_done;
  logic             row_edge;
  logic             last_row;
  logic             shifting;

  assign half_done     = (half_cnt == CNT_W'(SCLK_HALF - 1));
  assign row_edge      = rc_sync2 & ~rc_prev;
  assign row_index_inc = row_index_q + ROW_W'(1);
  assign last_row      = (row_index_inc == rows_target);

  // State register.
  always_ff @(posedge control_clock) begin
    if (external_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and Moore-style control outputs.
  always_comb begin
    state_next         = state;
    shifting           = 1'b0;
    sw.cfg_ready       = 1'b0;
    sw.busy            = 1'b1;
    sw.run_done_pulse  = 1'b0;
    sr_data            = 1'b0;
    sr_data_clock      = 1'b0;
    sr_div_data_reset  = 1'b0;
    sr_row_data_reset  = 1'b0;
    rowpack_enable     = 1'b0;
    row_starting       = 1'b0;
    reset_row          = 1'b0;

    case (state)
      IDLE: begin
        sw.cfg_ready = 1'b1;
        sw.busy      = 1'b0;
        // A load request takes priority; a run_start in the same cycle is dropped.
        if (sw.cfg_valid) begin
`ifdef CFG_CLEAR_BEFORE_LOAD_EN
          state_next = CLEAR;
`else
          state_next = SHIFT_LO;
`endif
        end else if (sw.run_start) begin
          state_next = (sw.run_rows == '0) ? FINISH : ARM;
        end
      end
`ifdef CFG_CLEAR_BEFORE_LOAD_EN
      CLEAR: begin
        sr_div_data_reset = ~load_select;
        sr_row_data_reset = load_select;
        state_next        = SHIFT_LO;
      end
`endif
      SHIFT_LO: begin
        shifting = 1'b1;
        sr_data  = load_value[bit_idx];
        if (half_done) begin
          state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        shifting      = 1'b1;
        sr_data       = load_value[bit_idx];
        sr_data_clock = 1'b1;
        if (half_done) begin
          state_next = (bit_idx == 5'd0) ? GUARD : SHIFT_LO;
        end
      end
      GUARD: begin
        shifting = 1'b1;
        if (half_done) begin
          state_next = IDLE;
        end
      end
      ARM: begin
        rowpack_enable = 1'b1;
        reset_row      = 1'b1;
        state_next     = sw.run_abort ? FINISH : WAIT_ROW;
      end
      WAIT_ROW: begin
        rowpack_enable = 1'b1;
        row_starting   = 1'b1;
        // A row edge coincident with abort is still counted before finishing.
        if (row_edge) begin
          state_next = (last_row || sw.run_abort) ? FINISH : ROW_GAP;
        end else if (sw.run_abort) begin
          state_next = FINISH;
        end
      end
      ROW_GAP: begin
        rowpack_enable = 1'b1;
        state_next     = sw.run_abort ? FINISH : ARM;
      end
      FINISH: begin
        sw.run_done_pulse = 1'b1;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    sr_div_data_enable = shifting & ~load_select;
    sr_row_data_enable = shifting & load_select;
    div_enable         = ~(shifting & ~load_select);
  end

  // Load datapath, half-period timing, row counting and row_complete synchroniser.
  always_ff @(posedge control_clock) begin
    if (external_reset) begin
      half_cnt    <= '0;
      bit_idx     <= '0;
      load_value  <= '0;
      load_select <= 1'b0;
      rows_target <= '0;
      row_index_q <= '0;
      row_done_q  <= 1'b0;
      rc_sync1    <= 1'b0;
      rc_sync2    <= 1'b0;
      rc_prev     <= 1'b0;
    end else begin
      rc_sync1   <= row_complete;
      rc_sync2   <= rc_sync1;
      rc_prev    <= rc_sync2;
      row_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (sw.cfg_valid) begin
            load_value  <= sw.cfg_value;
            load_select <= sw.cfg_select;
            bit_idx     <= 5'd31;
            half_cnt    <= '0;
          end else if (sw.run_start) begin
            rows_target <= sw.run_rows;
            row_index_q <= '0;
          end
        end
        SHIFT_LO, GUARD: begin
          half_cnt <= half_done ? '0 : half_cnt + CNT_W'(1);
        end
        SHIFT_HI: begin
          half_cnt <= half_done ? '0 : half_cnt + CNT_W'(1);
          if (half_done && (bit_idx != 5'd0)) begin
            bit_idx <= bit_idx - 5'd1;
          end
        end
        WAIT_ROW: begin
          if (row_edge) begin
            row_index_q <= row_index_inc;
            row_done_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sw.row_index      = row_index_q;
  assign sw.row_done_pulse = row_done_q;

endmodule

// File: tb/tb_divider_config_sequencer.sv
// Directed bench for divider_config_sequencer (SCLK_HALF=4, ROW_W=16).
// Outputs are sampled on the falling edge of control_clock.
module tb_divider_config_sequencer;

  localparam int unsigned SCLK_HALF = 4;
  localparam int unsigned ROW_W     = 16;

  logic control_clock  = 1'b0;
  logic external_reset = 1'b1;
  logic row_complete   = 1'b0;
  logic sr_data, sr_data_clock;
  logic sr_div_data_enable, sr_div_data_reset;
  logic sr_row_data_enable, sr_row_data_reset;
  logic div_enable, rowpack_enable, row_starting, reset_row;

  divider_config_sequencer_if #(.ROW_W(ROW_W)) sw_if ();

  divider_config_sequencer #(
    .SCLK_HALF(SCLK_HALF),
    .ROW_W    (ROW_W)
  ) dut (
    .control_clock     (control_clock),
    .external_reset    (external_reset),
    .sw                (sw_if),
    .row_complete      (row_complete),
    .sr_data           (sr_data),
    .sr_data_clock     (sr_data_clock),
    .sr_div_data_enable(sr_div_data_enable),
    .sr_div_data_reset (sr_div_data_reset),
    .sr_row_data_enable(sr_row_data_enable),
    .sr_row_data_reset (sr_row_data_reset),
    .div_enable        (div_enable),
    .rowpack_enable    (rowpack_enable),
    .row_starting      (row_starting),
    .reset_row         (reset_row)
  );

  always #5 control_clock = ~control_clock;

  int errors = 0;
  int checks = 0;

`ifdef CFG_CLEAR_BEFORE_LOAD_EN
  localparam int CLEAR_PULSES = 1;
`else
  localparam int CLEAR_PULSES = 0;
`endif

  // Running pulse totals; tests work with differences between snapshots.
  int n_reset_row = 0;
  int n_run_done  = 0;

  always @(negedge control_clock) begin
    if (!external_reset) begin
      if (reset_row)            n_reset_row++;
      if (sw_if.run_done_pulse) n_run_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one load at a falling edge and observe it until cfg_ready returns.
  task automatic do_load(input logic sel, input logic [31:0] val,
                         output logic [31:0] word, output int div_en, output int row_en,
                         output int div_low, output int edges, output int div_rst,
                         output int row_rst, output int rst_late, output logic timed_out);
    logic prev_clk;
    word = '0; div_en = 0; row_en = 0; div_low = 0; edges = 0;
    div_rst = 0; row_rst = 0; rst_late = 0; timed_out = 1'b1; prev_clk = 1'b0;
    sw_if.cfg_valid  = 1'b1;
    sw_if.cfg_select = sel;
    sw_if.cfg_value  = val;
    @(negedge control_clock);
    sw_if.cfg_valid = 1'b0;
    sw_if.run_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sw_if.cfg_ready) begin
        timed_out = 1'b0;
        break;
      end
      if (sr_div_data_enable) div_en++;
      if (sr_row_data_enable) row_en++;
      if (!div_enable)        div_low++;
      if (sr_div_data_reset || sr_row_data_reset) begin
        if (edges != 0) rst_late++;
      end
      if (sr_div_data_reset) div_rst++;
      if (sr_row_data_reset) row_rst++;
      if (sr_data_clock && !prev_clk) begin
        edges++;
        word = {word[30:0], sr_data};
      end
      prev_clk = sr_data_clock;
      @(negedge control_clock);
    end
  endtask

  task automatic start_run(input logic [ROW_W-1:0] rows);
    sw_if.run_rows  = rows;
    sw_if.run_start = 1'b1;
    @(negedge control_clock);
    sw_if.run_start = 1'b0;
  endtask

  // Wait for row_starting, raise row_complete, wait for the row_done pulse.
  task automatic complete_row(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !row_starting; i++) @(negedge control_clock);
    row_complete = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge control_clock);
      if (sw_if.row_done_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    row_complete = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] word;
    int div_en, row_en, div_low, edges, div_rst, row_rst, rst_late;
    logic timed_out, seen;
    int rr0, rd0;

    sw_if.cfg_valid  = 1'b0;
    sw_if.cfg_select = 1'b0;
    sw_if.cfg_value  = '0;
    sw_if.run_start  = 1'b0;
    sw_if.run_rows   = '0;
    sw_if.run_abort  = 1'b0;

    // Reset state.
    repeat (2) @(negedge control_clock);
    check("rst_cfg_ready",  32'(sw_if.cfg_ready), 32'd1);
    check("rst_div_enable", 32'(div_enable), 32'd1);
    check("rst_busy",       32'(sw_if.busy), 32'd0);
    check("rst_sr_bus",     32'({sr_data, sr_data_clock, sr_div_data_enable, sr_div_data_reset,
                                 sr_row_data_enable, sr_row_data_reset}), 32'd0);
    check("rst_run_outs",   32'({rowpack_enable, row_starting, reset_row,
                                 sw_if.row_done_pulse, sw_if.run_done_pulse}), 32'd0);
    check("rst_row_index",  32'(sw_if.row_index), 32'd0);
    external_reset = 1'b0;
    @(negedge control_clock);

    // Divider-target load.
    do_load(1'b0, 32'h0000_000A, word, div_en, row_en, div_low, edges, div_rst, row_rst, rst_late, timed_out);
    check("div_timeout",   32'(timed_out), 32'd0);
    check("div_word",      word, 32'h0000_000A);
    check("div_edges",     32'(edges), 32'd32);
    check("div_en_cycles", 32'(div_en), 32'd260);
    check("div_low",       32'(div_low), 32'd260);
    check("div_row_en",    32'(row_en), 32'd0);
    check("div_clr",       32'(div_rst), 32'(CLEAR_PULSES));
    check("div_ready",     32'(sw_if.cfg_ready), 32'd1);

    // Row-points load.
    do_load(1'b1, 32'hFFFF_0001, word, div_en, row_en, div_low, edges, div_rst, row_rst, rst_late, timed_out);
    check("row_timeout",   32'(timed_out), 32'd0);
    check("row_word",      word, 32'hFFFF_0001);
    check("row_edges",     32'(edges), 32'd32);
    check("row_en_cycles", 32'(row_en), 32'd260);
    check("row_div_low",   32'(div_low), 32'd0);
    check("row_clr",       32'(row_rst), 32'(CLEAR_PULSES));
    check("row_clr_late",  32'(rst_late + div_rst), 32'd0);

    // Three-row run.
    rr0 = n_reset_row; rd0 = n_run_done;
    start_run(16'd3);
    for (int k = 1; k <= 3; k++) begin
      complete_row(seen);
      check("run3_row_seen", 32'(seen), 32'd1);
      check("run3_row_index", 32'(sw_if.row_index), 32'(k));
    end
    check("run3_done_pulse", 32'(sw_if.run_done_pulse), 32'd1);
    repeat (3) @(negedge control_clock);
    #1;
    check("run3_reset_rows", 32'(n_reset_row - rr0), 32'd3);
    check("run3_run_done",   32'(n_run_done - rd0), 32'd1);
    check("run3_rowpack",    32'(rowpack_enable), 32'd0);
    check("run3_busy",       32'(sw_if.busy), 32'd0);

    // Five-row run aborted after the second row.
    rr0 = n_reset_row; rd0 = n_run_done;
    start_run(16'd5);
    for (int k = 1; k <= 2; k++) begin
      complete_row(seen);
      check("abort_row_seen", 32'(seen), 32'd1);
    end
    sw_if.run_abort = 1'b1;
    @(negedge control_clock);
    sw_if.run_abort = 1'b0;
    check("abort_done_pulse", 32'(sw_if.run_done_pulse), 32'd1);
    repeat (4) @(negedge control_clock);
    #1;
    check("abort_row_index",  32'(sw_if.row_index), 32'd2);
    check("abort_reset_rows", 32'(n_reset_row - rr0), 32'd2);
    check("abort_run_done",   32'(n_run_done - rd0), 32'd1);
    check("abort_busy",       32'(sw_if.busy), 32'd0);

    // Load and run_start together: the load wins, the run is dropped.
    rr0 = n_reset_row; rd0 = n_run_done;
    sw_if.run_rows  = 16'd4;
    sw_if.run_start = 1'b1;
    do_load(1'b0, 32'h8000_0001, word, div_en, row_en, div_low, edges, div_rst, row_rst, rst_late, timed_out);
    check("both_timeout",   32'(timed_out), 32'd0);
    check("both_word",      word, 32'h8000_0001);
    repeat (2) @(negedge control_clock);
    check("both_row_index", 32'(sw_if.row_index), 32'd2);
    check("both_busy",      32'(sw_if.busy), 32'd0);

    // Zero-row run.
    sw_if.run_rows  = 16'd0;
    sw_if.run_start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge control_clock);
      sw_if.run_start = 1'b0;
      if (sw_if.run_done_pulse) seen = 1'b1;
    end
    repeat (2) @(negedge control_clock);
    #1;
    check("zero_done_seen",  32'(seen), 32'd1);
    check("zero_run_done",   32'(n_run_done - rd0), 32'd1);
    check("zero_reset_rows", 32'(n_reset_row - rr0), 32'd0);
    check("zero_row_index",  32'(sw_if.row_index), 32'd0);

    // Reset in the middle of a load.
    @(negedge control_clock);
    sw_if.cfg_valid  = 1'b1;
    sw_if.cfg_select = 1'b0;
    sw_if.cfg_value  = 32'hDEAD_BEEF;
    @(negedge control_clock);
    sw_if.cfg_valid = 1'b0;
    repeat (20) @(negedge control_clock);
    check("mid_busy_before", 32'(sw_if.busy), 32'd1);
    external_reset = 1'b1;
    @(negedge control_clock);
    check("mid_cfg_ready",  32'(sw_if.cfg_ready), 32'd1);
    check("mid_div_enable", 32'(div_enable), 32'd1);
    check("mid_sr_bus",     32'({sr_data, sr_data_clock, sr_div_data_enable, sr_row_data_enable}), 32'd0);
    external_reset = 1'b0;
    repeat (2) @(negedge control_clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
